// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// with a start/busy/done handshake and registered results.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d_c;
  logic             br_nxt_c;
  logic [WIDTH-1:0] res_nxt_c;
  logic             last_c;

  // Full-subtractor cell on the current LSBs plus the borrow flop
  assign d_c       = sa[0] ^ sb[0] ^ br;
  assign br_nxt_c  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  assign res_nxt_c = {d_c, res[WIDTH-1:1]};
  assign last_c    = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // DONE accepts a new start exactly like IDLE
        IDLE, DONE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= res_nxt_c;
          br  <= br_nxt_c;
          if (last_c) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            diff  <= res_nxt_c;
            bout  <= br_nxt_c;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed scenarios and random
// operands at WIDTH=8, exhaustive sweep at WIDTH=4, against an arithmetic model.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       bin8;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       bout8;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       bin4;
  logic       busy4;
  logic       done4;
  logic [3:0] diff4;
  logic       bout4;

  int checks;
  int errors;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic modulo 2^w
  function automatic int unsigned ref_diff(input int unsigned w, input int unsigned x,
                                           input int unsigned y, input int unsigned c);
    int r;
    r = int'(x) - int'(y) - int'(c);
    return int'(r) & ((1 << w) - 1);
  endfunction

  function automatic bit ref_bout(input int unsigned x, input int unsigned y,
                                  input int unsigned c);
    return x < (y + c);
  endfunction

  // Issue one 8-bit op and wait (bounded) for done; returns at the done sample
  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                     output logic [7:0] od, output logic ob, output int lat,
                     output int busy_n, output bit both);
    a8 = ia; b8 = ib; bin8 = ibin; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    lat = 0; busy_n = 0; both = 0;
    while (!done8 && lat < 40) begin
      if (busy8) busy_n++;
      if (busy8 && done8) both = 1;
      tick();
      lat++;
    end
    if (busy8 && done8) both = 1;
    od = diff8;
    ob = bout8;
  endtask

  task automatic op4(input logic [3:0] ia, input logic [3:0] ib, input logic ibin,
                     output logic [3:0] od, output logic ob, output int lat);
    a4 = ia; b4 = ib; bin4 = ibin; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 20) begin
      tick();
      lat++;
    end
    od = diff4;
    ob = bout4;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy8, done8, diff8, bout8} !== 11'd0) begin
      errors++;
      $display("FAIL reset8 busy=%b done=%b diff=%h bout=%b required all 0",
               busy8, done8, diff8, bout8);
    end
    checks++;
    if ({busy4, done4, diff4, bout4} !== 7'd0) begin
      errors++;
      $display("FAIL reset4 busy=%b done=%b diff=%h bout=%b required all 0",
               busy4, done4, diff4, bout4);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] d; logic bo; int lat; int bn; bit both;
    op8(8'd5, 8'd3, 1'b0, d, bo, lat, bn, both);
    checks++;
    if (lat !== 8 || bn !== 8) begin
      errors++;
      $display("FAIL basic_timing latency=%0d busy_cycles=%0d required 8/8", lat, bn);
    end
    checks++;
    if (d !== 8'h02 || bo !== 1'b0 || both) begin
      errors++;
      $display("FAIL basic_result diff=%h bout=%b overlap=%0d required 02/0/0", d, bo, both);
    end
    tick();
    checks++;
    if (done8 !== 1'b0 || diff8 !== 8'h02) begin
      errors++;
      $display("FAIL basic_hold done=%b diff=%h required 0/02", done8, diff8);
    end
  endtask

  task automatic test_extremes();
    logic [7:0] ta [4];
    logic [7:0] tb [4];
    logic       tc [4];
    logic [7:0] d; logic bo; int lat; int bn; bit both;
    ta = '{8'd3, 8'h00, 8'hFF, 8'h80};
    tb = '{8'd5, 8'h00, 8'hFF, 8'h7F};
    tc = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      op8(ta[i], tb[i], tc[i], d, bo, lat, bn, both);
      checks++;
      if (d !== 8'(ref_diff(8, ta[i], tb[i], tc[i])) || bo !== ref_bout(ta[i], tb[i], tc[i])
          || lat !== 8) begin
        errors++;
        $display("FAIL extreme%0d a=%h b=%h bin=%b diff=%h bout=%b lat=%0d required %h/%b/8",
                 i, ta[i], tb[i], tc[i], d, bo, lat,
                 8'(ref_diff(8, ta[i], tb[i], tc[i])), ref_bout(ta[i], tb[i], tc[i]));
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [7:0] ra; logic [7:0] rb; logic rc;
    logic [7:0] d; logic bo; int lat; int bn; bit both;
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      op8(ra, rb, rc, d, bo, lat, bn, both);
      checks++;
      if (d !== 8'(ref_diff(8, ra, rb, rc)) || bo !== ref_bout(ra, rb, rc) || lat !== 8
          || bn !== 8 || both) begin
        errors++;
        $display("FAIL random a=%h b=%h bin=%b diff=%h bout=%b lat=%0d busy=%0d required %h/%b/8/8",
                 ra, rb, rc, d, bo, lat, bn, 8'(ref_diff(8, ra, rb, rc)), ref_bout(ra, rb, rc));
      end
      if (i % 3 == 0) tick();
    end
  endtask

  task automatic test_ignored_start();
    int pulses;
    logic [7:0] got;
    a8 = 8'd10; b8 = 8'd4; bin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    pulses = 0;
    got = 8'h00;
    tick();
    tick();
    a8 = 8'd1; b8 = 8'd2; start8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done8) begin
        pulses++;
        got = diff8;
      end
      tick();
    end
    checks++;
    if (pulses !== 1 || got !== 8'h06) begin
      errors++;
      $display("FAIL ignored_start pulses=%0d diff=%h required 1/06", pulses, got);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d; logic bo; int lat; int bn; bit both;
    op8(8'd50, 8'd8, 1'b0, d, bo, lat, bn, both);
    checks++;
    if (d !== 8'd42 || bo !== 1'b0 || done8 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first diff=%h bout=%b done=%b required 2a/0/1", d, bo, done8);
    end
    op8(8'd20, 8'd7, 1'b0, d, bo, lat, bn, both);
    checks++;
    if (lat + 1 !== 9 || d !== 8'h0D || bo !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second gap=%0d diff=%h bout=%b required 9/0d/0", lat + 1, d, bo);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int pulses;
    logic [7:0] d; logic bo; int lat; int bn; bit both;
    a8 = 8'd100; b8 = 8'd1; bin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({busy8, done8, diff8, bout8} !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid busy=%b done=%b diff=%h bout=%b required all 0",
               busy8, done8, diff8, bout8);
    end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (done8 || busy8) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_mid_quiet active_cycles=%0d required 0", pulses);
    end
    op8(8'd100, 8'd1, 1'b0, d, bo, lat, bn, both);
    checks++;
    if (d !== 8'd99 || bo !== 1'b0 || lat !== 8) begin
      errors++;
      $display("FAIL reset_mid_fresh diff=%h bout=%b lat=%0d required 63/0/8", d, bo, lat);
    end
    tick();
  endtask

  task automatic test_sweep4();
    logic [3:0] d; logic bo; int lat;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int c = 0; c < 2; c++) begin
          op4(4'(x), 4'(y), 1'(c), d, bo, lat);
          checks++;
          if (d !== 4'(ref_diff(4, x, y, c)) || lat !== 4) begin
            errors++;
            $display("FAIL sweep4_diff a=%0d b=%0d bin=%0d diff=%h lat=%0d required %h/4",
                     x, y, c, d, lat, 4'(ref_diff(4, x, y, c)));
          end
          checks++;
          if (bo !== ref_bout(x, y, c)) begin
            errors++;
            $display("FAIL sweep4_bout a=%0d b=%0d bin=%0d bout=%b required %b",
                     x, y, c, bo, ref_bout(x, y, c));
          end
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    test_reset();
    test_basic();
    test_extremes();
    test_random();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_sweep4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
